// File: rtl/countdown_timer_bcd_disp.sv
// rtl/countdown_timer_bcd_disp.sv - game countdown timer with sequential BCD conversion and multiplexed 7-segment display
//
// Purpose:
//   Counts down once per tick and subtracts PENALTY on each rising edge of
//   miss. When the count reaches zero the block flags a sticky game failure.
//   The binary count is converted to BCD by a shift-add-3 engine, with no
//   dividers. The digits are scanned out to common-anode 7-segment displays.
//
// Ports:
//   clock          in   1       system clock
//   reset          in   1       synchronous, active-high
//   enable         in   1       1 = run, 0 = pause (tick divider holds)
//   load           in   1       restart: count = START_VALUE, clear fail
//   miss           in   1       level; each rising edge applies PENALTY once
//   timer_out      out  CNT_W   current binary count
//   game_fail_out  out  1       sticky, set when the count reaches 0
//   tick_out       out  1       one-cycle pulse per tick
//   a..g           out  1 each  segments, active-low
//   dp             out  1       decimal point, active-high in the DP_POS slot
//   an             out  DIGITS  digit enables, active-low one-hot
module countdown_timer_bcd_disp #(
    parameter int TICK_DIV    = 5000,
    parameter int CNT_W       = 21,
    parameter int START_VALUE = 1800000,
    parameter int PENALTY     = 10000,
    parameter int DIGITS      = 8,
    parameter int DP_POS      = 4,
    parameter int SCAN_DIV    = 8,
    parameter int LZ_BLANK    = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              load,
    input  logic              miss,
    output logic [CNT_W-1:0]  timer_out,
    output logic              game_fail_out,
    output logic              tick_out,
    output logic              a,
    output logic              b,
    output logic              c,
    output logic              d,
    output logic              e,
    output logic              f,
    output logic              g,
    output logic              dp,
    output logic [DIGITS-1:0] an
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = CNT_W + 1;
    localparam int BW = 4 * DIGITS;
    localparam int SW = $clog2(CNT_W + 1);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Elaboration-time BCD of the reset value, so the display shows the
    // start count immediately after reset without a conversion pass.
    function automatic logic [BW-1:0] to_bcd(input longint value);
        longint rem;
        to_bcd = '0;
        rem    = value;
        for (int i = 0; i < DIGITS; i++) begin
            to_bcd[4*i +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
    endfunction

    localparam logic [BW-1:0]    RESET_BCD = to_bcd(longint'(START_VALUE));
    localparam logic [CNT_W-1:0] START_CNT = CNT_W'(START_VALUE);
    localparam logic [AW-1:0]    PEN_AMT   = AW'(PENALTY);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_COMMIT = 2'd2
    } conv_state_t;

    // Tick divider and count
    logic [TW-1:0]    r_ticker;
    logic [CNT_W-1:0] r_timer;
    logic             r_fail;
    logic             r_miss_q;
    logic             w_tick;
    logic             w_edge;
    logic [AW-1:0]    w_amount;
    logic             w_timer_wr;

    // BCD converter
    conv_state_t      r_state;
    conv_state_t      w_state_next;
    logic             r_dirty;
    logic             w_capture;
    logic [CNT_W-1:0] r_bin;
    logic [BW-1:0]    r_bcd;
    logic [BW-1:0]    w_bcd_adj;
    logic [SW-1:0]    r_shift_cnt;
    logic [BW-1:0]    r_digits;

    // Display scan
    logic [DW-1:0]     r_scan_div;
    logic [IW-1:0]     r_scan_idx;
    logic [DIGITS-1:0] w_lz;
    logic              w_zero_run;
    logic [3:0]        w_digit;
    logic              w_digit_lz;
    logic              w_blank;
    logic [6:0]        w_seg_dec;
    logic [6:0]        w_seg;

    // The divider only advances while running; a failed game freezes it.
    assign w_tick = enable & ~r_fail & (r_ticker == TW'(TICK_DIV - 1));
    assign w_edge = miss & ~r_miss_q;

    // A penalty edge and a tick in the same cycle combine into one subtraction.
    assign w_amount   = (w_edge ? PEN_AMT : {AW{1'b0}}) + AW'(w_tick);
    assign w_timer_wr = load | (~r_fail & (w_amount != {AW{1'b0}}));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ticker <= '0;
        end else if (load) begin
            r_ticker <= '0;
        end else if (enable && !r_fail) begin
            if (r_ticker == TW'(TICK_DIV - 1)) begin
                r_ticker <= '0;
            end else begin
                r_ticker <= r_ticker + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_timer  <= START_CNT;
            r_fail   <= 1'b0;
            r_miss_q <= 1'b0;
        end else begin
            // The edge register follows miss even while paused or failed.
            r_miss_q <= miss;
            if (load) begin
                r_timer <= START_CNT;
                r_fail  <= 1'b0;
            end else if (!r_fail && (w_amount != {AW{1'b0}})) begin
                // Saturate at zero. The fail flag is set in the same cycle
                // that zero is written.
                if ({1'b0, r_timer} <= w_amount) begin
                    r_timer <= '0;
                    r_fail  <= 1'b1;
                end else begin
                    r_timer <= r_timer - w_amount[CNT_W-1:0];
                end
            end
        end
    end

    // Converter state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_dirty) begin
                    w_capture    = 1'b1;
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_shift_cnt == SW'(CNT_W - 1)) begin
                    w_state_next = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // If a new write lands in the same cycle as a capture, the set wins so
    // the newer value still gets converted.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dirty <= 1'b0;
        end else if (w_timer_wr) begin
            r_dirty <= 1'b1;
        end else if (w_capture) begin
            r_dirty <= 1'b0;
        end
    end

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bin       <= '0;
            r_bcd       <= '0;
            r_shift_cnt <= '0;
            r_digits    <= RESET_BCD;
        end else begin
            if (w_capture) begin
                r_bin       <= r_timer;
                r_bcd       <= '0;
                r_shift_cnt <= '0;
            end else if (r_state == S_SHIFT) begin
                r_bcd       <= {w_bcd_adj[BW-2:0], r_bin[CNT_W-1]};
                r_bin       <= {r_bin[CNT_W-2:0], 1'b0};
                r_shift_cnt <= r_shift_cnt + 1'b1;
            end
            // All digits update together, so the display never shows a
            // partially converted value.
            if (r_state == S_COMMIT) begin
                r_digits <= r_bcd;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_scan_div <= '0;
            r_scan_idx <= '0;
        end else if (r_scan_div == DW'(SCAN_DIV - 1)) begin
            r_scan_div <= '0;
            if (r_scan_idx == IW'(DIGITS - 1)) begin
                r_scan_idx <= '0;
            end else begin
                r_scan_idx <= r_scan_idx + 1'b1;
            end
        end else begin
            r_scan_div <= r_scan_div + 1'b1;
        end
    end

    // w_lz[i] is set when digit i and every digit above it are zero.
    always_comb begin
        w_zero_run = 1'b1;
        w_lz       = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run & (r_digits[4*i +: 4] == 4'd0);
            w_lz[i]    = w_zero_run;
        end
    end

    always_comb begin
        w_digit    = 4'd0;
        w_digit_lz = 1'b0;
        an         = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scan_idx == IW'(i)) begin
                w_digit    = r_digits[4*i +: 4];
                w_digit_lz = w_lz[i];
                an[i]      = 1'b0;
            end
        end
    end

    assign w_blank = (LZ_BLANK != 0) && (int'(r_scan_idx) > DP_POS) && w_digit_lz;

    always_comb begin
        w_seg_dec = 7'b1111111;
        case (w_digit)
            4'd0:    w_seg_dec = 7'b1000000;
            4'd1:    w_seg_dec = 7'b1111001;
            4'd2:    w_seg_dec = 7'b0100100;
            4'd3:    w_seg_dec = 7'b0110000;
            4'd4:    w_seg_dec = 7'b0011001;
            4'd5:    w_seg_dec = 7'b0010010;
            4'd6:    w_seg_dec = 7'b0000010;
            4'd7:    w_seg_dec = 7'b1111000;
            4'd8:    w_seg_dec = 7'b0000000;
            4'd9:    w_seg_dec = 7'b0010000;
            default: w_seg_dec = 7'b1111111;
        endcase
    end

    // On failure every slot shows a dash, overriding both digits and blanking.
    assign w_seg = r_fail  ? 7'b0111111 :
                   w_blank ? 7'b1111111 : w_seg_dec;

    assign {g, f, e, d, c, b, a} = w_seg;
    assign dp            = (int'(r_scan_idx) == DP_POS);
    assign timer_out     = r_timer;
    assign game_fail_out = r_fail;
    assign tick_out      = w_tick;

endmodule

// File: tb/tb_countdown_timer_bcd_disp.sv
// tb/tb_countdown_timer_bcd_disp.sv - self-checking bench for countdown_timer_bcd_disp
module tb_countdown_timer_bcd_disp;

    localparam int TICK_DIV = 40;
    localparam int CNT_W    = 8;
    localparam int START_V  = 25;
    localparam int PENALTY  = 10;
    localparam int DIGITS   = 4;
    localparam int DP_POS   = 1;
    localparam int SCAN_DIV = 2;
    localparam int SETTLE   = 24;

    logic             clock  = 1'b0;
    logic             reset  = 1'b1;
    logic             enable = 1'b0;
    logic             load   = 1'b0;
    logic             miss   = 1'b0;
    logic [CNT_W-1:0] timer_out;
    logic             game_fail_out;
    logic             tick_out;
    logic             a, b, c, d, e, f, g;
    logic             dp;
    logic [DIGITS-1:0] an;

    countdown_timer_bcd_disp #(
        .TICK_DIV   (TICK_DIV),
        .CNT_W      (CNT_W),
        .START_VALUE(START_V),
        .PENALTY    (PENALTY),
        .DIGITS     (DIGITS),
        .DP_POS     (DP_POS),
        .SCAN_DIV   (SCAN_DIV),
        .LZ_BLANK   (1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .load         (load),
        .miss         (miss),
        .timer_out    (timer_out),
        .game_fail_out(game_fail_out),
        .tick_out     (tick_out),
        .a            (a),
        .b            (b),
        .c            (c),
        .d            (d),
        .e            (e),
        .f            (f),
        .g            (g),
        .dp           (dp),
        .an           (an)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int m_cnt, m_ticker, m_scan, m_last_wr, cyc;
    bit m_fail, m_missq, m_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h at step %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s wait bound expired observed=timeout expected=condition", tag);
    endtask

    function automatic int p10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] seg_code(input int dgt);
        case (dgt)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // One clock: check the current state at the falling edge, then advance the model.
    task automatic step();
        int         idx, amt;
        bit         tk, edg;
        logic [3:0] an_exp;
        logic [6:0] seg_exp;
        @(negedge clock);
        if (m_valid) begin
            tk = enable && !m_fail && (m_ticker == TICK_DIV - 1);
            chk("timer_out", 32'(timer_out), 32'(m_cnt));
            chk("game_fail", 32'(game_fail_out), 32'(m_fail));
            chk("tick_out", 32'(tick_out), 32'(tk));
            idx    = (m_scan / SCAN_DIV) % DIGITS;
            an_exp = ~(4'b0001 << idx);
            chk("an", 32'(an), 32'(an_exp));
            chk("dp", 32'(dp), 32'(idx == DP_POS));
            if (m_fail || (cyc - m_last_wr) > SETTLE) begin
                if (m_fail) seg_exp = 7'b0111111;
                else if (idx > DP_POS && m_cnt < p10(idx)) seg_exp = 7'b1111111;
                else seg_exp = seg_code((m_cnt / p10(idx)) % 10);
                chk("segments", 32'({g, f, e, d, c, b, a}), 32'(seg_exp));
            end
        end
        if (reset) begin
            m_cnt = START_V; m_fail = 0; m_missq = 0; m_ticker = 0;
            m_scan = 0; m_last_wr = cyc - 100; m_valid = 1;
        end else begin
            tk  = enable && !m_fail && (m_ticker == TICK_DIV - 1);
            edg = miss && !m_missq;
            amt = (edg ? PENALTY : 0) + (tk ? 1 : 0);
            if (load) m_ticker = 0;
            else if (enable && !m_fail) m_ticker = (m_ticker + 1) % TICK_DIV;
            if (load) begin
                m_cnt = START_V; m_fail = 0; m_last_wr = cyc;
            end else if (!m_fail && amt > 0) begin
                if (m_cnt <= amt) begin m_cnt = 0; m_fail = 1; end
                else m_cnt = m_cnt - amt;
                m_last_wr = cyc;
            end
            m_missq = miss;
            m_scan++;
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    initial begin
        int n;
        cyc = 0; m_valid = 0; m_cnt = 0; m_ticker = 0; m_scan = 0;
        m_last_wr = 0; m_fail = 0; m_missq = 0;
        #1;
        // Reset state and initial display
        reset = 1;
        repeat (3) step();
        reset = 0;

        // Free run: ticks on the 40th and 80th cycle
        enable = 1;
        repeat (80) step();
        chk("run_80_count", 32'(timer_out), 32'd23);
        repeat (30) step();

        // Held miss applies the penalty once
        enable = 0;
        miss   = 1;
        repeat (100) step();
        chk("held_miss_count", 32'(timer_out), 32'd13);
        miss = 0;
        step();

        // Miss edge coincident with a tick at count 23
        load = 1; step(); load = 0;
        enable = 1;
        n = 0;
        while (!(m_cnt == 23 && m_ticker == TICK_DIV - 1) && n < 1000) begin step(); n++; end
        if (n >= 1000) bound_fail("reach_23_tick");
        miss = 1;
        step();
        chk("miss_plus_tick", 32'(timer_out), 32'd12);
        miss = 0;

        // Saturate to zero and hold while failed
        n = 0;
        while (m_cnt != 5 && n < 1000) begin step(); n++; end
        if (n >= 1000) bound_fail("reach_5");
        enable = 0;
        miss   = 1;
        step();
        chk("sat_zero", 32'(timer_out), 32'd0);
        chk("sat_fail", 32'(game_fail_out), 32'd1);
        enable = 1;
        for (int i = 0; i < 100; i++) begin miss = (i % 7) < 3; step(); end
        chk("fail_hold_count", 32'(timer_out), 32'd0);
        miss = 0;

        // Load during a conversion at count 12
        load = 1; step(); load = 0;
        enable = 0; miss = 1; step(); miss = 0;
        enable = 1;
        n = 0;
        while (m_cnt != 12 && n < 1000) begin step(); n++; end
        if (n >= 1000) bound_fail("reach_12");
        repeat (4) step();
        load = 1; step(); load = 0;
        chk("load_count", 32'(timer_out), 32'(START_V));
        chk("load_fail", 32'(game_fail_out), 32'd0);
        chk("load_ticker", 32'(tick_out), 32'd0);
        enable = 0;
        repeat (30) step();

        // Pause at count 5 with leading-zero blanking
        miss = 1; step(); miss = 0; step();
        miss = 1; step(); miss = 0;
        repeat (200) step();
        chk("pause_count", 32'(timer_out), 32'd5);

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom % 8) != 0;
            load   = ($urandom % 250) == 0;
            reset  = ($urandom % 1500) == 0;
            if (($urandom % 25) == 0) miss = ~miss;
            step();
        end
        reset = 0; load = 0; enable = 0; miss = 0;
        repeat (40) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
